// File: rtl/apb_csr_mb.sv
// APB3 CSR block: NUM_BANKS dual-port word banks (port A on APB, port B to the accelerator),
// generic config registers, start/busy/done handshake, sticky W1C status and a level irq.

module apb_csr_mb_bank #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_we,
  input  logic          a_re,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] a_rdata_q, b_dout_q;

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (a_re) a_rdata_q <= mem[a_addr];
  end

  // port B output register is reset, array contents are not; NBA gives read-first
  always_ff @(posedge clk or posedge rst)
    if (rst)       b_dout_q <= '0;
    else if (b_en) b_dout_q <= mem[b_addr];

  assign a_rdata = a_rdata_q;
  assign b_dout  = b_dout_q;
endmodule

module apb_csr_mb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_AW    = 10,
  parameter int NUM_BANKS  = 4,
  parameter int NUM_CFG    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            PSEL,
  input  logic                            PENABLE,
  input  logic                            PWRITE,
  input  logic [ADDR_WIDTH-1:0]           PADDR,
  input  logic [DATA_WIDTH-1:0]           PWDATA,
  output logic [DATA_WIDTH-1:0]           PRDATA,
  output logic                            PREADY,
  output logic                            PSLVERR,
  output logic [NUM_CFG*DATA_WIDTH-1:0]   cfg_out,
  output logic                            start,
  output logic                            accel_reset,
  input  logic                            done_in,
  output logic                            irq,
  input  logic [NUM_BANKS-1:0]            b_en,
  input  logic [NUM_BANKS*BRAM_AW-1:0]    b_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] b_dout
);
  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;

  localparam logic [3:0] NB4   = 4'(NUM_BANKS);
  localparam logic [9:0] NCFG  = 10'(NUM_CFG);

  rd_state_e rd_state_q, rd_state_d;
  logic [NUM_CFG-1:0][DATA_WIDTH-1:0]   cfg_q, cfg_d;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
  logic [NUM_BANKS-1:0] bank_we, bank_re;
  logic [1:0] ie_q, ie_d;
  logic ar_q, ar_d, start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
  logic [3:0]  page;
  logic [11:0] off;
  logic [9:0]  widx;
  logic bank_hit, reg_pg, cfg_hit, ctrl_hit, stat_hit, ie_hit, reg_hit, mapped;
  logic access, wr, start_req;
  logic [DATA_WIDTH-1:0] reg_rdata, sel_rdata;
  logic unused_paddr;

  assign unused_paddr = ^PADDR[ADDR_WIDTH-1:16];

  // decode
  assign page     = PADDR[15:12];
  assign off      = PADDR[11:0];
  assign widx     = off[11:2];
  assign bank_hit = page < NB4;
  assign reg_pg   = page == 4'hF;
  assign cfg_hit  = reg_pg && off[1:0] == 2'b00 && widx < NCFG;
  assign ctrl_hit = reg_pg && off == 12'h100;
  assign stat_hit = reg_pg && off == 12'h104;
  assign ie_hit   = reg_pg && off == 12'h108;
  assign reg_hit  = cfg_hit | ctrl_hit | stat_hit | ie_hit;
  assign mapped   = bank_hit | reg_hit;

  // reset gates the bus so a transfer caught by reset sees an idle, ready slave at once
  assign access = PSEL & PENABLE & ~rst;
  assign wr     = access & PWRITE & (rd_state_q == RD_IDLE) & mapped;

  for (genvar r = 0; r < NUM_BANKS; r++) begin : g_bank
    apb_csr_mb_bank #(.DW(DATA_WIDTH), .AW(BRAM_AW)) u_bank (
      .clk(clk), .rst(rst),
      .a_we(bank_we[r]), .a_re(bank_re[r]), .a_addr(PADDR[BRAM_AW+1:2]),
      .a_wdata(PWDATA), .a_rdata(bank_rdata[r]),
      .b_en(b_en[r]), .b_addr(b_addr[r*BRAM_AW +: BRAM_AW]),
      .b_dout(b_dout[r*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    reg_rdata = '0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_CFG; i++)
      if (cfg_hit && widx == 10'(i)) reg_rdata = cfg_q[i];
    if (ctrl_hit) reg_rdata[1]   = ar_q;
    if (stat_hit) reg_rdata[2:0] = {err_q, done_q, busy_q};
    if (ie_hit)   reg_rdata[1:0] = ie_q;
    for (int r = 0; r < NUM_BANKS; r++)
      if (page == 4'(r)) sel_rdata = bank_rdata[r];
  end

  // bank read wait-state FSM and APB response
  always_comb begin
    rd_state_d = rd_state_q;
    PREADY     = 1'b1;
    PRDATA     = '0;
    PSLVERR    = 1'b0;
    bank_re    = '0;
    bank_we    = '0;
    for (int r = 0; r < NUM_BANKS; r++)
      bank_we[r] = wr & bank_hit & (page == 4'(r));
    case (rd_state_q)
      RD_IDLE: begin
        PSLVERR = access & ~mapped;
        if (access && !PWRITE && bank_hit) begin
          for (int r = 0; r < NUM_BANKS; r++)
            bank_re[r] = page == 4'(r);
          PREADY     = 1'b0;
          rd_state_d = RD_WAIT;
        end else if (access && !PWRITE && reg_hit) begin
          PRDATA = reg_rdata;
        end
      end
      RD_WAIT: begin
        PRDATA     = sel_rdata;
        rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    cfg_d = cfg_q;
    for (int i = 0; i < NUM_CFG; i++)
      if (wr && cfg_hit && widx == 10'(i)) cfg_d[i] = PWDATA;
    ie_d      = (wr && ie_hit) ? PWDATA[1:0] : ie_q;
    ar_d      = (wr && ctrl_hit) ? PWDATA[1] : ar_q;
    start_req = wr & ctrl_hit & PWDATA[0];
    start_d   = start_req & ~busy_q;
    busy_d    = busy_q;
    if (done_in) busy_d = 1'b0;
    if (start_d) busy_d = 1'b1;
    if (ar_q)    busy_d = 1'b0;
    // set terms are OR'd after the clear so a same-cycle event wins over W1C
    done_d = (done_q & ~(wr & stat_hit & PWDATA[1])) | done_in;
    err_d  = (err_q  & ~(wr & stat_hit & PWDATA[2])) | (start_req & busy_q);
    irq_d  = (done_q & ie_q[0]) | (err_q & ie_q[1]);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_state_q <= RD_IDLE;
      cfg_q      <= '0;
      ie_q       <= '0;
      ar_q       <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      cfg_q      <= cfg_d;
      ie_q       <= ie_d;
      ar_q       <= ar_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end

  assign cfg_out     = cfg_q;
  assign start       = start_q;
  assign accel_reset = ar_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_apb_csr_mb.sv
// Self-checking bench for apb_csr_mb: randomized APB/port-B traffic against a behavioural model.

module tb_apb_csr_mb;
  localparam int AW = 32, DW = 32, BAW = 10, NB = 4, NC = 8;

  logic clk = 1'b0;
  logic rst;
  logic PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic PREADY, PSLVERR;
  logic [NC*DW-1:0] cfg_out;
  logic start, accel_reset, done_in, irq;
  logic [NB-1:0] b_en;
  logic [NB*BAW-1:0] b_addr;
  logic [NB*DW-1:0] b_dout;

  always #5 clk = ~clk;

  apb_csr_mb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_AW(BAW), .NUM_BANKS(NB), .NUM_CFG(NC)) dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .cfg_out(cfg_out),
    .start(start), .accel_reset(accel_reset), .done_in(done_in), .irq(irq),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout));

  int vectors = 0, miscompares = 0, start_cnt = 0;

  // behavioural model
  logic [DW-1:0] m_mem [NB][1<<BAW];
  logic [DW-1:0] m_cfg [NC];
  bit m_busy, m_done, m_err, m_ar;
  bit [1:0] m_ie;
  int m_pulses = 0;

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  function automatic logic [2:0] m_status();
    return {m_err, m_done, m_busy};
  endfunction
  function automatic logic m_irq();
    return (m_done & m_ie[0]) | (m_err & m_ie[1]);
  endfunction
  function automatic logic [NC*DW-1:0] m_cfg_vec();
    logic [NC*DW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = m_cfg[i];
    return v;
  endfunction
  function automatic void m_reset();
    for (int i = 0; i < NC; i++) m_cfg[i] = '0;
    m_busy = 0; m_done = 0; m_err = 0; m_ar = 0; m_ie = '0;
  endfunction

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic dn,
                           output logic rdy, output logic err, output logic [31:0] rd);
    @(negedge clk); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    @(negedge clk); PENABLE = 1; done_in = dn;
    #1; rdy = PREADY; err = PSLVERR; rd = PRDATA;
    @(posedge clk);
    @(negedge clk); PSEL = 0; PENABLE = 0; PWRITE = 0; done_in = 0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err, output int waits);
    @(negedge clk); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    @(negedge clk); PENABLE = 1; waits = 0;
    #1;
    while (PREADY !== 1'b1 && waits < 4) begin @(negedge clk); #1; waits++; end
    d = PRDATA; err = PSLVERR;
    @(posedge clk);
    @(negedge clk); PSEL = 0; PENABLE = 0;
  endtask

  task automatic done_pulse();
    @(negedge clk); done_in = 1;
    @(negedge clk); done_in = 0;
    m_busy = 0; m_done = 1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic e; int w;
    #1;
    vectors++; if (PREADY !== 1'b1) begin miscompares++; $display("FAIL rst_pready: got %b exp 1", PREADY); end
    vectors++; if (PRDATA !== '0) begin miscompares++; $display("FAIL rst_prdata: got %h exp 0", PRDATA); end
    vectors++; if (PSLVERR !== 1'b0) begin miscompares++; $display("FAIL rst_pslverr: got %b exp 0", PSLVERR); end
    vectors++; if ({start, accel_reset, irq} !== 3'b000) begin miscompares++; $display("FAIL rst_outs: got %b exp 000", {start, accel_reset, irq}); end
    vectors++; if (cfg_out !== '0) begin miscompares++; $display("FAIL rst_cfg: got %h exp 0", cfg_out); end
    vectors++; if (b_dout !== '0) begin miscompares++; $display("FAIL rst_bdout: got %h exp 0", b_dout); end
    apb_read(32'hF104, rd, e, w);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_status: got %h exp 0", rd); end
    apb_read(32'hF108, rd, e, w);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_irqen: got %h exp 0", rd); end
  endtask

  task automatic test_bank();
    logic rdy, e; logic [31:0] rd; int w;
    int wl [NB][6];
    apb_write(32'h2014, 32'hDEADBEEF, 0, rdy, e, rd); m_mem[2][5] = 32'hDEADBEEF;
    vectors++; if ({rdy, e} !== 2'b10) begin miscompares++; $display("FAIL bank_wr_resp: got rdy/err %b exp 10", {rdy, e}); end
    apb_read(32'h2014, rd, e, w);
    vectors++; if (w !== 1) begin miscompares++; $display("FAIL bank_rd_waits: got %0d exp 1", w); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL bank_rd: got %h exp deadbeef", rd); end
    @(negedge clk); b_en = 4'b0100; b_addr[2*BAW +: BAW] = 10'd5;
    @(negedge clk); b_en = '0; b_addr[2*BAW +: BAW] = 10'd6;
    vectors++; if (b_dout[2*DW +: DW] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL portb_rd: got %h exp deadbeef", b_dout[2*DW +: DW]); end
    @(negedge clk);
    vectors++; if (b_dout[2*DW +: DW] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL portb_hold: got %h exp deadbeef", b_dout[2*DW +: DW]); end
    // random fill, then read back through both ports
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < 6; k++) begin
        logic [31:0] d;
        wl[b][k] = int'($urandom_range(0, (1 << BAW) - 1));
        d = $urandom;
        apb_write((b << 12) | (wl[b][k] << 2), d, 0, rdy, e, rd);
        m_mem[b][wl[b][k]] = d;
      end
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < 6; k++) begin
        apb_read((b << 12) | (wl[b][k] << 2), rd, e, w);
        vectors++; if (rd !== m_mem[b][wl[b][k]] || w !== 1) begin miscompares++; $display("FAIL bank_rand b%0d w%0d: got %h/%0d exp %h/1", b, wl[b][k], rd, w, m_mem[b][wl[b][k]]); end
      end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); b_en = '1;
      for (int b = 0; b < NB; b++) b_addr[b*BAW +: BAW] = wl[b][k][BAW-1:0];
      @(negedge clk); b_en = '0;
      for (int b = 0; b < NB; b++) begin
        vectors++; if (b_dout[b*DW +: DW] !== m_mem[b][wl[b][k]]) begin miscompares++; $display("FAIL portb_rand b%0d: got %h exp %h", b, b_dout[b*DW +: DW], m_mem[b][wl[b][k]]); end
      end
    end
  endtask

  task automatic test_read_first();
    logic rdy, e; logic [31:0] rd;
    apb_write(32'h301C, 32'h1111_1111, 0, rdy, e, rd); m_mem[3][7] = 32'h1111_1111;
    @(negedge clk); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h301C; PWDATA = 32'h2222_2222;
    @(negedge clk); PENABLE = 1; b_en = 4'b1000; b_addr[3*BAW +: BAW] = 10'd7;
    @(negedge clk); PSEL = 0; PENABLE = 0; PWRITE = 0; b_en = '0; m_mem[3][7] = 32'h2222_2222;
    vectors++; if (b_dout[3*DW +: DW] !== 32'h1111_1111) begin miscompares++; $display("FAIL read_first_old: got %h exp 11111111", b_dout[3*DW +: DW]); end
    b_en = 4'b1000;
    @(negedge clk); b_en = '0;
    vectors++; if (b_dout[3*DW +: DW] !== 32'h2222_2222) begin miscompares++; $display("FAIL read_first_new: got %h exp 22222222", b_dout[3*DW +: DW]); end
  endtask

  task automatic test_cfg();
    logic rdy, e; logic [31:0] rd; int w;
    apb_write(32'hF00C, 32'h0000_1234, 0, rdy, e, rd); m_cfg[3] = 32'h1234;
    apb_read(32'hF00C, rd, e, w);
    vectors++; if (rd !== 32'h1234 || w !== 0) begin miscompares++; $display("FAIL cfg3: got %h/%0d exp 1234/0", rd, w); end
    vectors++; if (cfg_out[127:96] !== 32'h1234) begin miscompares++; $display("FAIL cfg3_out: got %h exp 1234", cfg_out[127:96]); end
    for (int i = 0; i < NC; i++) begin
      logic [31:0] d; d = $urandom;
      apb_write(32'hF000 + 4 * i, d, 0, rdy, e, rd); m_cfg[i] = d;
    end
    for (int i = 0; i < NC; i++) begin
      apb_read(32'hF000 + 4 * i, rd, e, w);
      vectors++; if (rd !== m_cfg[i] || w !== 0) begin miscompares++; $display("FAIL cfg_rand%0d: got %h/%0d exp %h/0", i, rd, w, m_cfg[i]); end
    end
    vectors++; if (cfg_out !== m_cfg_vec()) begin miscompares++; $display("FAIL cfg_out: got %h exp %h", cfg_out, m_cfg_vec()); end
  endtask

  task automatic test_start();
    logic rdy, e; logic [31:0] rd; int w, c0;
    apb_write(32'hF108, 32'h1, 0, rdy, e, rd); m_ie = 2'b01;
    c0 = start_cnt;
    apb_write(32'hF100, 32'h1, 0, rdy, e, rd); m_busy = 1; m_pulses++;
    #1;
    vectors++; if (start !== 1'b1) begin miscompares++; $display("FAIL start_pulse: got %b exp 1", start); end
    @(negedge clk); #1;
    vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL start_end: got %b exp 0", start); end
    apb_read(32'hF104, rd, e, w);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL status_busy: got %h exp 1", rd); end
    done_pulse(); #1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_lag: got %b exp 0", irq); end
    @(negedge clk); #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b exp 1", irq); end
    apb_read(32'hF104, rd, e, w);
    vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL status_done: got %h exp 2", rd); end
    apb_write(32'hF104, 32'h2, 0, rdy, e, rd); m_done = 0;
    apb_read(32'hF104, rd, e, w);
    vectors++; if (rd !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL w1c_done: got %h irq %b exp 0 irq 0", rd, irq); end
    // second start while busy: no pulse, err set
    c0 = start_cnt;
    apb_write(32'hF100, 32'h1, 0, rdy, e, rd); m_busy = 1; m_pulses++;
    apb_write(32'hF100, 32'h1, 0, rdy, e, rd); m_err = 1;
    apb_read(32'hF104, rd, e, w);
    vectors++; if (start_cnt - c0 !== 1) begin miscompares++; $display("FAIL single_pulse: got %0d exp 1", start_cnt - c0); end
    vectors++; if (rd !== 32'h5) begin miscompares++; $display("FAIL status_err: got %h exp 5", rd); end
    done_pulse();
    // done_in coincides with W1C of done and err: done survives, err clears
    apb_write(32'hF104, 32'h6, 1, rdy, e, rd); m_done = 1; m_err = 0;
    apb_read(32'hF104, rd, e, w);
    vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL set_wins: got %h exp 2", rd); end
    apb_write(32'hF104, 32'h6, 0, rdy, e, rd); m_done = 0;
  endtask

  task automatic test_accel_reset();
    logic rdy, e; logic [31:0] rd; int w;
    apb_write(32'hF100, 32'h1, 0, rdy, e, rd); m_busy = 1; m_pulses++;
    apb_write(32'hF100, 32'h1, 0, rdy, e, rd); m_err = 1;
    apb_write(32'hF100, 32'h2, 0, rdy, e, rd); m_ar = 1; m_busy = 0;
    vectors++; if (accel_reset !== 1'b1) begin miscompares++; $display("FAIL accel_reset_set: got %b exp 1", accel_reset); end
    apb_read(32'hF100, rd, e, w);
    vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL control_rd: got %h exp 2", rd); end
    apb_read(32'hF104, rd, e, w);
    vectors++; if (rd !== {29'd0, m_status()}) begin miscompares++; $display("FAIL ar_status: got %h exp %h", rd, m_status()); end
    apb_write(32'hF100, 32'h0, 0, rdy, e, rd); m_ar = 0;
    vectors++; if (accel_reset !== 1'b0) begin miscompares++; $display("FAIL accel_reset_clr: got %b exp 0", accel_reset); end
    apb_write(32'hF104, 32'h6, 0, rdy, e, rd); m_err = 0; m_done = 0;
  endtask

  task automatic test_handshake_rand();
    logic rdy, e; logic [31:0] rd; int w, c0, p0;
    c0 = start_cnt; p0 = m_pulses;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0: begin
          apb_write(32'hF100, 32'h1, 0, rdy, e, rd);
          if (m_busy) m_err = 1; else begin m_busy = 1; m_pulses++; end
        end
        1: done_pulse();
        2: begin
          d = $urandom_range(0, 7);
          apb_write(32'hF104, d, 0, rdy, e, rd);
          if (d[1]) m_done = 0;
          if (d[2]) m_err = 0;
        end
        default: begin
          d = $urandom_range(0, 3);
          apb_write(32'hF108, d, 0, rdy, e, rd); m_ie = d[1:0];
        end
      endcase
      apb_read(32'hF104, rd, e, w);
      vectors++; if (rd !== {29'd0, m_status()} || irq !== m_irq()) begin miscompares++; $display("FAIL hs_rand%0d: got st %h irq %b exp st %h irq %b", n, rd, irq, m_status(), m_irq()); end
    end
    vectors++; if (start_cnt - c0 !== m_pulses - p0) begin miscompares++; $display("FAIL hs_pulses: got %0d exp %0d", start_cnt - c0, m_pulses - p0); end
  endtask

  task automatic test_unmapped();
    logic rdy, e; logic [31:0] rd; int w;
    logic [31:0] addrs [5];
    addrs[0] = 32'h5000; addrs[1] = 32'hF200; addrs[2] = 32'hF020; addrs[3] = 32'hF10C; addrs[4] = 32'hE000;
    apb_write(32'h1000, 32'hA5A5_0001, 0, rdy, e, rd); m_mem[1][0] = 32'hA5A5_0001;
    for (int k = 0; k < 5; k++) begin
      apb_write(addrs[k], $urandom, 0, rdy, e, rd);
      vectors++; if ({rdy, e} !== 2'b11 || rd !== '0) begin miscompares++; $display("FAIL unmap_wr %h: got rdy/err %b data %h exp 11 0", addrs[k], {rdy, e}, rd); end
      apb_read(addrs[k], rd, e, w);
      vectors++; if (w !== 0 || e !== 1'b1 || rd !== '0) begin miscompares++; $display("FAIL unmap_rd %h: got w%0d err %b data %h exp w0 1 0", addrs[k], w, e, rd); end
    end
    vectors++; if (cfg_out !== m_cfg_vec()) begin miscompares++; $display("FAIL unmap_cfg: got %h exp %h", cfg_out, m_cfg_vec()); end
    apb_read(32'h1000, rd, e, w);
    vectors++; if (rd !== m_mem[1][0] || e !== 1'b0) begin miscompares++; $display("FAIL unmap_bank: got %h err %b exp %h 0", rd, e, m_mem[1][0]); end
    apb_read(32'hF104, rd, e, w);
    vectors++; if (rd !== {29'd0, m_status()}) begin miscompares++; $display("FAIL unmap_status: got %h exp %h", rd, m_status()); end
  endtask

  task automatic test_reset_mid_read();
    logic rdy, e; logic [31:0] rd; int w;
    apb_write(32'hF004, 32'hCAFE_0001, 0, rdy, e, rd); m_cfg[1] = 32'hCAFE_0001;
    apb_write(32'hF108, 32'h3, 0, rdy, e, rd); m_ie = 2'b11;
    done_pulse();
    @(negedge clk); b_en = 4'b0100; b_addr[2*BAW +: BAW] = 10'd5;
    @(negedge clk); b_en = '0;
    @(negedge clk); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h2014;
    @(negedge clk); PENABLE = 1; #1;
    vectors++; if (PREADY !== 1'b0 || irq !== 1'b1) begin miscompares++; $display("FAIL pre_rst: got rdy %b irq %b exp 0 1", PREADY, irq); end
    @(negedge clk); rst = 1; #1;
    vectors++; if (PREADY !== 1'b1 || PRDATA !== '0 || PSLVERR !== 1'b0) begin miscompares++; $display("FAIL mid_rst_bus: got rdy %b data %h err %b exp 1 0 0", PREADY, PRDATA, PSLVERR); end
    vectors++; if ({start, accel_reset, irq} !== 3'b000 || cfg_out !== '0 || b_dout !== '0) begin miscompares++; $display("FAIL mid_rst_regs: got %b cfg %h bdout %h exp 000 0 0", {start, accel_reset, irq}, cfg_out, b_dout); end
    @(negedge clk); PSEL = 0; PENABLE = 0; rst = 0;
    m_reset();
    apb_read(32'h2014, rd, e, w);
    vectors++; if (rd !== m_mem[2][5] || w !== 1 || e !== 1'b0) begin miscompares++; $display("FAIL post_rst_rd: got %h/%0d err %b exp %h/1 0", rd, w, e, m_mem[2][5]); end
    apb_read(32'hF104, rd, e, w);
    vectors++; if (rd !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL post_rst_status: got %h irq %b exp 0 0", rd, irq); end
  endtask

  initial begin
    rst = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    done_in = 0; b_en = '0; b_addr = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    test_reset();
    test_bank();
    test_read_first();
    test_cfg();
    test_start();
    test_accel_reset();
    test_handshake_rand();
    test_unmapped();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion exp finish");
    $fatal(1);
  end
endmodule

// File: doc/apb_csr_mb.md
Name: apb_csr_mb

Overview:
- APB3 slave: configuration/control CSR block with NUM_BANKS internal dual-port word memories (weights, clauses, thresholds, ...).
- Port A (APB) writes and reads every bank with one wait state on bank reads. Port B of each bank is a read port for the accelerator datapath.
- Adds a start/busy/done handshake, sticky status with write-1-to-clear, an interrupt and PSLVERR on unmapped addresses.
- Sits between the SoC APB interconnect and the accelerator core, replacing the fixed two-bank CSR.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB/bank data width.
- BRAM_AW, 10, word-address width of each bank (2^BRAM_AW words).
- NUM_BANKS, 4, number of memory banks (1..15).
- NUM_CFG, 8, number of generic DATA_WIDTH configuration registers (1..64).

Ports:
- clk  in  1  single clock for APB and port B.
- rst  in  1  asynchronous active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB write.
- PADDR  in  ADDR_WIDTH  APB byte address.
- PWDATA  in  DATA_WIDTH  APB write data.
- PRDATA  out  DATA_WIDTH  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- cfg_out  out  NUM_CFG*DATA_WIDTH  config regs, reg i at [i*DATA_WIDTH +: DATA_WIDTH].
- start  out  1  one-cycle start pulse.
- accel_reset  out  1  level soft reset to accelerator.
- done_in  in  1  accelerator completion pulse.
- irq  out  1  level interrupt.
- b_en  in  NUM_BANKS  per-bank port-B read enable.
- b_addr  in  NUM_BANKS*BRAM_AW  per-bank port-B word address.
- b_dout  out  NUM_BANKS*DATA_WIDTH  per-bank port-B read data.

Behaviour:
- Address decode:
  - PADDR[15:12]=r with r<NUM_BANKS selects bank r; word address = PADDR[BRAM_AW+1:2].
  - PADDR[15:12]=0xF selects the register page, decoded on offset PADDR[11:0]:
    - 0x000+4i: CFG[i], i<NUM_CFG.
    - 0x100: CONTROL — bit0 start (write-only, reads 0), bit1 accel_reset.
    - 0x104: STATUS — bit0 busy (RO), bit1 done (sticky, W1C), bit2 err (sticky, W1C).
    - 0x108: IRQ_EN — bit0 done_ie, bit1 err_ie.
  - Anything else is unmapped.
- Writes are zero-wait: PREADY=1 in the access cycle; the update takes effect at that clock edge.
- Bank reads take one wait state, driven by a 2-state FSM, RD_IDLE -> RD_WAIT:
  - In RD_IDLE, the first access cycle (PSEL&PENABLE&~PWRITE, bank hit) issues the memory read; PREADY=0; move to RD_WAIT.
  - In RD_WAIT, PREADY=1 and PRDATA = registered bank data; return to RD_IDLE.
- Register reads are zero-wait, with combinational PRDATA in the access cycle. PRDATA=0 outside a read access.
- Unmapped access, read or write, completes zero-wait with PREADY=1, PSLVERR=1 and PRDATA=0; no state changes. PSLVERR=0 otherwise.
- Start handshake:
  - Writing CONTROL with bit0=1 while busy=0 drives start=1 for exactly one cycle, on the cycle after the write edge, and sets busy=1.
  - Writing CONTROL with bit0=1 while busy=1 produces no pulse and sets err=1.
  - done_in=1 clears busy and sets done. done_in while busy=0 still sets done.
- W1C and set collisions: done_in (or an err condition) in the same cycle as a W1C write to the same bit leaves the bit set; set wins.
- accel_reset=1 forces busy=0 and does not clear done or err.
- irq = (done&done_ie) | (err&err_ie), registered, so it follows status by 1 cycle.
- Port B:
  - Synchronous read on clk; b_dout slice updates the cycle after b_en=1 and holds when b_en=0.
  - A same-cycle port-A write and port-B read to the same address returns old data (read-first).
  - Bank contents are not reset.
- Reset (async, any time, including mid-read):
  - All CFG, IRQ_EN and STATUS bits = 0; start=0, accel_reset=0, irq=0.
  - FSM returns to RD_IDLE; PRDATA=0, PREADY=1, PSLVERR=0; b_dout=0.
  - A transaction interrupted by reset is abandoned; the master must restart it.

Test Plan:
- Write 0xDEADBEEF to bank 2 word 5 (PADDR 0x2014), then read back -> write completes with PREADY=1 in the first access cycle; read gets PREADY=0 then 1, PRDATA=0xDEADBEEF; b_en[2]=1, b_addr=5 -> b_dout slice 0xDEADBEEF one cycle later.
- Write CFG[3]=0x0000_1234 (PADDR 0xF00C) and read back -> PRDATA=0x1234, cfg_out[127:96]=0x1234, no wait state.
- Write IRQ_EN=0x1, then CONTROL=0x1 -> start high for one cycle, STATUS reads 0x1. Pulse done_in -> STATUS reads 0x2, irq=1 next cycle. Write STATUS=0x2 -> STATUS=0, irq=0.
- Write CONTROL=0x1 twice without done_in -> a single start pulse, STATUS.err=1. Same-cycle done_in and W1C of done -> done stays 1.
- Access PADDR 0x5000 with NUM_BANKS=4, and PADDR 0xF200 -> PSLVERR=1, PRDATA=0, no register or bank change.
- Assert rst during RD_WAIT of a bank read -> PREADY=1, PRDATA=0, start=0, all registers 0 immediately; a subsequent read succeeds normally.
